awg_sweep_ctrl: RTL and testbench
=================================

# awg_sweep_ctrl

Frequency-sweep sequencer for the AWG sine channel. Sits directly upstream of the sine generator and drives its enable, frequency-step, amplitude and phase controls. It steps the frequency word from a start value to a stop value in fixed increments, holding each value for a programmable dwell. Supports single-shot and continuous sweeps, plus an optional triangle (up-then-down) profile.

## Interface
- FREQ_W, 12, width of frequency word (phase-accumulator step)
- AMP_W, 8, amplitude word width
- PH_W, 8, phase word width
- DWELL_W, 16, dwell counter width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse, begin sweep (honoured only in IDLE)
- stop  in  1  level/pulse, abort sweep
- cont  in  1  1 = continuous repeat, 0 = single shot; sampled at start
- tri  in  1  1 = triangle profile; sampled at start; ignored unless AWG_SWEEP_TRI_EN
- f_start, f_stop, f_step  in  FREQ_W  sweep bounds/increment; sampled at start
- dwell  in  DWELL_W  cycles per frequency point; sampled at start
- ld_ap  in  1  load amp_in/phase_in (any state)
- amp_in  in  AMP_W  amplitude
- phase_in  in  PH_W  phase
- en  out  1  sine generator enable
- state_freq  out  FREQ_W  current frequency word
- state_amp  out  AMP_W  registered amplitude
- state_phase  out  PH_W  registered phase
- busy  out  1  high in any non-IDLE state
- done  out  1  1-cycle pulse on natural sweep completion

## Operation
- States: IDLE, DWELL, STEP.
- IDLE: en=0, busy=0, state_freq holds its last value. Start (with no stop) latches all sweep inputs. Direction is up if f_stop >= f_start, else down.
- DWELL: state_freq is held while the dwell counter runs. Effective dwell is max(dwell,1) cycles.
- STEP: occupies 0 cycles of output time; the next point is computed in the same cycle the dwell expires.
- Next point is computed in FREQ_W+1 bits (no wrap). Up: f+f_step, clamped to f_stop. Down: f−f_step, clamped to f_stop.
- Dwell expiry at f_stop (no triangle):
  - cont=1: reload f_start, stay in DWELL.
  - cont=0: done=1 for one cycle, go to IDLE.
- f_step=0 or f_start=f_stop: a single point of one dwell, then the end rule above applies.
- stop in any state: IDLE next cycle, en=0, no done pulse. start is ignored while busy. If start and stop are both asserted in IDLE, stop wins.
- ld_ap: state_amp/state_phase update on the next cycle, independent of the FSM.
- Reset values: en=0, busy=0, done=0, state_freq=0, state_amp=0, state_phase=0, FSM=IDLE, dwell counter=0. Reset mid-sweep aborts immediately (asynchronous).

## Timing
- start at edge N → at edge N+1: en=1, busy=1, state_freq=f_start.
- Each point is visible for exactly max(dwell,1) cycles; the next value appears on the edge where the counter expires.
- Single sweep of P points: done is asserted P·max(dwell,1) cycles after en rises. At that same edge, en=0 and busy=0.
- Continuous wrap f_stop→f_start: no gap cycle.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- AWG_SWEEP_TRI_EN defined:
  - tri=1 reverses direction on reaching f_stop and sweeps back to f_start; f_stop is held for one dwell only, not two.
  - Single-shot: done on return to f_start.
  - Continuous: reverses again at f_start, indefinitely.
- Undefined: the tri input is unused and no reverse logic is synthesized; behaviour is identical to tri=0.

## Structure
- Shared package awg_pkg: FSM state enum (IDLE/DWELL/STEP), default width constants FREQ_W/AMP_W/PH_W/DWELL_W.
- One sub-module: awg_dwell_timer (load, count down, expire pulse; DWELL_W-wide, treats 0 as 1).
- The step/clamp arithmetic stays in awg_sweep_ctrl.

## Test plan
- f_start=100, f_stop=130, f_step=10, dwell=4, cont=0:
  - state_freq = 100,110,120,130, each for 4 cycles.
  - done pulses at cycle 16 after en rises; en=0 at that edge.
- f_step=12, same bounds, dwell=1 → sequence 100,112,124,130 (clamped), then done.
- f_start=50, f_stop=20, f_step=15, dwell=2 → 50,35,20, then done. Also with dwell=0 → each point lasts 1 cycle.
- cont=1, 100→120 step 10, dwell=3:
  - 100,110,120,100,… with no gap.
  - stop asserted mid-point → IDLE next cycle, en=0, no done.
  - rst_n pulled low mid-sweep → all outputs 0 asynchronously.
- Start and stop asserted in the same cycle in IDLE → stays IDLE. ld_ap with amp_in=0xA5, phase_in=0x3C during a sweep → outputs update next cycle and the sweep is undisturbed.
- With AWG_SWEEP_TRI_EN, tri=1, 100→120 step 10, dwell=2, cont=0 → 100,110,120,110,100, then done.

Source files
------------

// File: rtl/awg_pkg.sv
// -----------------------------------------------------------------------------
// awg_pkg
// Shared definitions for the AWG sweep sequencer.
//   - Default widths for the frequency, amplitude, phase and dwell words.
//   - Sweep FSM state encoding (IDLE / DWELL / STEP).
// -----------------------------------------------------------------------------
package awg_pkg;

  localparam int FREQ_W  = 12;  // phase-accumulator step word
  localparam int AMP_W   = 8;   // amplitude word
  localparam int PH_W    = 8;   // phase offset word
  localparam int DWELL_W = 16;  // cycles-per-point counter

  // STEP has no output time of its own: the next frequency point is
  // computed in the same cycle the dwell expires, so the FSM only ever
  // rests in IDLE or DWELL. The encoding is kept so the three phases of a
  // sweep have names in waveforms and in the case statement.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/awg_dwell_timer.sv
// -----------------------------------------------------------------------------
// awg_dwell_timer
// Per-point dwell counter for the sweep sequencer. On load it latches the
// dwell period (a period of 0 is treated as 1) and then produces a one-cycle
// expire pulse every max(dwell,1) cycles, reloading itself automatically,
// until cleared.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   stop counting (abort or sweep finished)
//   load    in   latch dwell and start counting
//   dwell   in   cycles per point, DWELL_W bits
//   expire  out  high during the last cycle of each dwell period
// -----------------------------------------------------------------------------
module awg_dwell_timer #(
  parameter int DWELL_W = awg_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] period_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic               active_reg;
  logic [DWELL_W-1:0] load_period;

  // The counter runs from period down to 0, so period = max(dwell,1) - 1.
  assign load_period = (dwell == '0) ? '0 : dwell - 1'b1;

  assign expire = active_reg && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      period_reg <= load_period;
      cnt_reg    <= load_period;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      cnt_reg <= (cnt_reg == '0) ? period_reg : cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// awg_sweep_ctrl
// Frequency-sweep sequencer feeding the AWG sine generator. Steps the
// frequency word from f_start to f_stop in f_step increments (clamped at
// f_stop, no wrap), holding each point for max(dwell,1) cycles. Single-shot
// or continuous; optional triangle (up-then-down) profile.
//
// Build option
//   AWG_SWEEP_TRI_EN  when defined, tri_mode=1 (latched at start) reverses
//                     the sweep at f_stop and returns to f_start. When
//                     undefined, tri_mode is ignored and no reverse logic
//                     exists.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    begin sweep (IDLE only; stop has priority)
//   stop                     abort to IDLE, no done pulse
//   cont                     continuous repeat (latched at start)
//   tri_mode                 triangle profile (latched at start); named
//                            tri_mode because 'tri' is a reserved word
//   f_start, f_stop, f_step  sweep bounds and increment (latched at start)
//   dwell                    cycles per point (latched at start)
//   ld_ap, amp_in, phase_in  amplitude/phase load, any state
//   en                       sine generator enable
//   state_freq               current frequency word
//   state_amp, state_phase   registered amplitude / phase
//   busy                     high whenever not IDLE
//   done                     one-cycle pulse on natural completion
// All outputs are registered.
// -----------------------------------------------------------------------------
module awg_sweep_ctrl #(
  parameter int FREQ_W  = awg_pkg::FREQ_W,
  parameter int AMP_W   = awg_pkg::AMP_W,
  parameter int PH_W    = awg_pkg::PH_W,
  parameter int DWELL_W = awg_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic               tri_mode,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ld_ap,
  input  logic [AMP_W-1:0]   amp_in,
  input  logic [PH_W-1:0]    phase_in,
  output logic               en,
  output logic [FREQ_W-1:0]  state_freq,
  output logic [AMP_W-1:0]   state_amp,
  output logic [PH_W-1:0]    state_phase,
  output logic               busy,
  output logic               done
);

  import awg_pkg::*;

  sweep_state_t       state_reg;
  logic [FREQ_W-1:0]  freq_reg;
  logic [FREQ_W-1:0]  f_start_reg;
  logic [FREQ_W-1:0]  f_stop_reg;
  logic [FREQ_W-1:0]  f_step_reg;
  logic               dir_up_reg;
  logic               cont_reg;
  logic               en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [AMP_W-1:0]   amp_reg;
  logic [PH_W-1:0]    phase_reg;

  logic               returning_reg;  // triangle: on the way back to f_start
  logic               can_turn;       // triangle reversal is meaningful

  logic               start_ok;
  logic               expire;
  logic               point_done;
  logic               timer_clr;
  logic [FREQ_W-1:0]  target;
  logic               go_up;
  logic [FREQ_W-1:0]  fwd_freq;
  logic [FREQ_W-1:0]  turn_freq;
  logic               at_end;
  logic               turn_now;
  logic [FREQ_W-1:0]  next_freq;
  logic               finish;

  // Next point toward target, computed one bit wider so the sum/difference
  // cannot wrap before the clamp is applied.
  function automatic logic [FREQ_W-1:0] next_point(
    input logic [FREQ_W-1:0] f,
    input logic [FREQ_W-1:0] step,
    input logic [FREQ_W-1:0] tgt,
    input logic              up
  );
    logic [FREQ_W:0] wide;
    if (up) begin
      wide = {1'b0, f} + {1'b0, step};
      if (wide >= {1'b0, tgt}) wide = {1'b0, tgt};
    end else begin
      if ({1'b0, f} <= ({1'b0, tgt} + {1'b0, step})) wide = {1'b0, tgt};
      else                                          wide = {1'b0, f} - {1'b0, step};
    end
    return wide[FREQ_W-1:0];
  endfunction

  assign start_ok   = (state_reg == IDLE) && start && !stop;
  assign point_done = (state_reg == DWELL) && expire && !stop;

  // STEP action: evaluated combinationally and committed on the expiry edge.
  always_comb begin
    target    = returning_reg ? f_start_reg : f_stop_reg;
    go_up     = returning_reg ? ~dir_up_reg : dir_up_reg;
    fwd_freq  = next_point(freq_reg, f_step_reg, target, go_up);
    turn_freq = next_point(freq_reg, f_step_reg,
                           returning_reg ? f_stop_reg : f_start_reg, ~go_up);
    // A zero step can never reach f_stop, so it counts as a one-point sweep.
    at_end    = (freq_reg == target) || (f_step_reg == '0);
    // Turning at f_stop always happens; turning back at f_start only repeats
    // in continuous mode. The turn point's value is shown once, not twice.
    turn_now  = can_turn && at_end && (!returning_reg || cont_reg);
    next_freq = freq_reg;
    finish    = 1'b0;
    if (!at_end)        next_freq = fwd_freq;
    else if (turn_now)  next_freq = turn_freq;
    else if (cont_reg)  next_freq = f_start_reg;
    else                finish    = 1'b1;
  end

  assign timer_clr = stop || (point_done && finish);

  awg_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .load   (start_ok),
    .dwell  (dwell),
    .expire (expire)
  );

`ifdef AWG_SWEEP_TRI_EN
  logic tri_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_reg       <= 1'b0;
      returning_reg <= 1'b0;
    end else if (start_ok) begin
      tri_reg       <= tri_mode;
      returning_reg <= 1'b0;
    end else if (point_done && turn_now) begin
      returning_reg <= ~returning_reg;
    end
  end

  // A one-point sweep has nothing to reverse over.
  assign can_turn = tri_reg && (f_step_reg != '0) && (f_start_reg != f_stop_reg);
`else
  logic unused_tri_mode;
  assign unused_tri_mode = tri_mode;
  assign returning_reg   = 1'b0;
  assign can_turn        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      freq_reg    <= '0;
      f_start_reg <= '0;
      f_stop_reg  <= '0;
      f_step_reg  <= '0;
      dir_up_reg  <= 1'b1;
      cont_reg    <= 1'b0;
      en_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      amp_reg     <= '0;
      phase_reg   <= '0;
    end else begin
      done_reg <= 1'b0;

      if (ld_ap) begin
        amp_reg   <= amp_in;
        phase_reg <= phase_in;
      end

      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            f_start_reg <= f_start;
            f_stop_reg  <= f_stop;
            f_step_reg  <= f_step;
            dir_up_reg  <= (f_stop >= f_start);
            cont_reg    <= cont;
            freq_reg    <= f_start;
            en_reg      <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= DWELL;
          end
        end

        DWELL: begin
          if (stop) begin
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (expire) begin
            if (finish) begin
              done_reg  <= 1'b1;
              en_reg    <= 1'b0;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              freq_reg <= next_freq;
            end
          end
        end

        default: begin
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign en          = en_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign state_freq  = freq_reg;
  assign state_amp   = amp_reg;
  assign state_phase = phase_reg;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_awg_sweep_ctrl
// Self-checking bench for awg_sweep_ctrl. A reference model derives the
// list of sweep points from the bounds/step/profile with plain integer
// arithmetic and walks it one point per dwell; a compare process checks all
// outputs on every falling edge. Directed sweeps pin the model to
// hand-computed sequences; randomized sweeps then cover the rest.
// Build with +define+AWG_SWEEP_TRI_EN to also cover the triangle profile.
// -----------------------------------------------------------------------------
module tb_awg_sweep_ctrl;

  localparam int FW = 12;
  localparam int AW = 8;
  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          stop     = 1'b0;
  logic          cont     = 1'b0;
  logic          tri_sel  = 1'b0;
  logic [FW-1:0] f_start  = '0;
  logic [FW-1:0] f_stop   = '0;
  logic [FW-1:0] f_step   = '0;
  logic [DW-1:0] dwell    = '0;
  logic          ld_ap    = 1'b0;
  logic [AW-1:0] amp_in   = '0;
  logic [PW-1:0] phase_in = '0;

  logic          en;
  logic [FW-1:0] state_freq;
  logic [AW-1:0] state_amp;
  logic [PW-1:0] state_phase;
  logic          busy;
  logic          done;

  int total  = 0;
  int bad    = 0;
  int nprint = 0;

  awg_sweep_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .tri_mode    (tri_sel),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .ld_ap       (ld_ap),
    .amp_in      (amp_in),
    .phase_in    (phase_in),
    .en          (en),
    .state_freq  (state_freq),
    .state_amp   (state_amp),
    .state_phase (state_phase),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int            m_pts[$];
  int            m_idx  = 0;
  int            m_left = 0;
  int            m_eff  = 1;
  bit            m_cont = 1'b0;
  logic          m_en   = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [FW-1:0] m_freq = '0;
  logic [AW-1:0] m_amp  = '0;
  logic [PW-1:0] m_phase = '0;

  function automatic int toward(input int p, input int st, input int tgt);
    if (tgt >= p) return (p + st > tgt) ? tgt : p + st;
    else          return (p - st < tgt) ? tgt : p - st;
  endfunction

  // Full ordered list of points for one pass (one period when continuous).
  function automatic void build_points(input int fs, input int fe, input int st,
                                       input bit tri_on, input bit cont_on);
    int p;
    m_pts.delete();
    p = fs;
    m_pts.push_back(p);
    while (st != 0 && p != fe) begin
      p = toward(p, st, fe);
      m_pts.push_back(p);
    end
    if (tri_on && st != 0 && fs != fe) begin
      p = fe;
      while (p != fs) begin
        p = toward(p, st, fs);
        if (!(cont_on && p == fs)) m_pts.push_back(p);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int nidx;
    bit tri_on;
    if (!rst_n) begin
      m_en    <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_freq  <= '0;
      m_amp   <= '0;
      m_phase <= '0;
    end else begin
      m_done <= 1'b0;
      if (ld_ap) begin
        m_amp   <= amp_in;
        m_phase <= phase_in;
      end
      if (!m_busy) begin
        if (start && !stop) begin
`ifdef AWG_SWEEP_TRI_EN
          tri_on = tri_sel;
`else
          tri_on = 1'b0;
`endif
          build_points(int'(f_start), int'(f_stop), int'(f_step), tri_on, cont);
          m_cont <= cont;
          m_eff  <= (dwell == '0) ? 1 : int'(dwell);
          m_left <= (dwell == '0) ? 1 : int'(dwell);
          m_idx  <= 0;
          m_freq <= f_start;
          m_en   <= 1'b1;
          m_busy <= 1'b1;
        end
      end else if (stop) begin
        m_en   <= 1'b0;
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        nidx = m_idx + 1;
        if (nidx == m_pts.size()) nidx = m_cont ? 0 : -1;
        if (nidx < 0) begin
          m_done <= 1'b1;
          m_en   <= 1'b0;
          m_busy <= 1'b0;
        end else begin
          m_idx  <= nidx;
          m_freq <= FW'(m_pts[nidx]);
          m_left <= m_eff;
        end
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clk) begin
    total++;
    if ({en, busy, done, state_freq, state_amp, state_phase} !==
        {m_en, m_busy, m_done, m_freq, m_amp, m_phase}) begin
      bad++;
      if (nprint < 25) begin
        nprint++;
        $display("FAIL cycle_check t=%0t dut en=%b busy=%b done=%b freq=%0d amp=%h ph=%h required en=%b busy=%b done=%b freq=%0d amp=%h ph=%h",
                 $time, en, busy, done, state_freq, state_amp, state_phase,
                 m_en, m_busy, m_done, m_freq, m_amp, m_phase);
      end
    end
  end

  // ------------------------------------------------------------- helpers
  int exp_q[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, req);
    end
  endtask

  task automatic drive_start(input int fs, input int fe, input int st, input int dw,
                             input bit cn, input bit tr);
    @(posedge clk); #1;
    f_start = FW'(fs);
    f_stop  = FW'(fe);
    f_step  = FW'(st);
    dwell   = DW'(dw);
    cont    = cn;
    tri_sel = tr;
    start   = 1'b1;
  endtask

  // Single-shot sweep against a hand-computed point list in exp_q.
  task automatic run_directed(input string name, input int fs, input int fe,
                              input int st, input int dw, input bit tr);
    int eff;
    int done_j;
    int trace[$];
    bit ok;
    eff = (dw == 0) ? 1 : dw;
    drive_start(fs, fe, st, dw, 1'b0, tr);
    @(posedge clk); #1;
    start  = 1'b0;
    done_j = -1;
    for (int j = 0; j < 600; j++) begin
      @(negedge clk);
      if (done) begin
        done_j = j;
        break;
      end
      if (en) trace.push_back(int'(state_freq));
    end
    check({name, "_done_time"}, done_j, exp_q.size() * eff);
    check({name, "_en_at_done"}, int'(en), 0);
    ok = (trace.size() == exp_q.size() * eff);
    for (int i = 0; i < trace.size() && ok; i++)
      if (trace[i] != exp_q[i / eff]) ok = 1'b0;
    check({name, "_trace_ok"}, int'(ok), 1);
    $display("txn %s: %0d->%0d step=%0d dwell=%0d tri=%0b points=%0d done_after=%0d",
             name, fs, fe, st, dw, tr, exp_q.size(), done_j);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int trace[$];
    bit ok;
    int fs, fe, st, dw, span, run_len, stop_at;
    bit cn, tr, early, timed_out;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'({en, busy, done, state_freq, state_amp, state_phase}), 0);

    exp_q = '{100, 110, 120, 130};
    run_directed("up_exact", 100, 130, 10, 4, 1'b0);
    exp_q = '{100, 112, 124, 130};
    run_directed("up_clamp", 100, 130, 12, 1, 1'b0);
    exp_q = '{50, 35, 20};
    run_directed("down_d2", 50, 20, 15, 2, 1'b0);
    exp_q = '{50, 35, 20};
    run_directed("down_d0", 50, 20, 15, 0, 1'b0);
    exp_q = '{4080, 4090, 4095};
    run_directed("top_nowrap", 4080, 4095, 10, 1, 1'b0);
    exp_q = '{15, 5, 0};
    run_directed("bottom_nowrap", 15, 0, 10, 1, 1'b0);
    exp_q = '{77};
    run_directed("equal_bounds", 77, 77, 5, 2, 1'b0);
    exp_q = '{100};
    run_directed("zero_step", 100, 130, 0, 3, 1'b0);
`ifdef AWG_SWEEP_TRI_EN
    exp_q = '{100, 110, 120, 110, 100};
    run_directed("triangle", 100, 120, 10, 2, 1'b1);
`endif

    // Continuous wrap with no gap, then stop mid-point.
    drive_start(100, 120, 10, 3, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    exp_q = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 100, 100, 100, 110};
    trace.delete();
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      trace.push_back(int'(state_freq));
    end
    ok = 1'b1;
    for (int i = 0; i < 13; i++) if (trace[i] != exp_q[i]) ok = 1'b0;
    check("cont_wrap_trace_ok", int'(ok), 1);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_en_busy_done", int'({en, busy, done}), 0);
    $display("txn cont_stop: 100->120 step=10 dwell=3 stopped mid-point");

    // Asynchronous reset mid-sweep.
    drive_start(100, 120, 10, 3, 1'b1, 1'b0);
    @(posedge clk); #1;
    start    = 1'b0;
    ld_ap    = 1'b1;
    amp_in   = 8'h11;
    phase_in = 8'h22;
    @(posedge clk); #1;
    ld_ap = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({en, busy, done, state_freq, state_amp, state_phase}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("txn async_reset: outputs cleared mid-sweep");

    // Start and stop together in IDLE.
    drive_start(100, 130, 10, 2, 1'b0, 1'b0);
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check("start_stop_same_cycle", int'({en, busy}), 0);
    $display("txn start_and_stop: stays idle");

    // ld_ap during a single-shot sweep.
    drive_start(100, 130, 10, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ld_ap    = 1'b1;
    amp_in   = 8'hA5;
    phase_in = 8'h3C;
    @(posedge clk); #1;
    ld_ap = 1'b0;
    @(negedge clk);
    check("ld_ap_amp", int'(state_amp), 8'hA5);
    check("ld_ap_phase", int'(state_phase), 8'h3C);
    timed_out = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("ld_ap_sweep_finishes", int'(timed_out), 0);
    $display("txn ld_ap: amp=a5 phase=3c loaded mid-sweep");

    // Randomized sweeps; inputs are scrambled while busy to exercise latching.
    for (int t = 0; t < 40; t++) begin
      fs   = $urandom_range(0, 4095);
      span = $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 1) fe = (fs + span > 4095) ? 4095 : fs + span;
      else                           fe = (fs - span < 0) ? 0 : fs - span;
      st      = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 25);
      dw      = $urandom_range(0, 3);
      cn      = ($urandom_range(0, 2) == 0);
      tr      = ($urandom_range(0, 1) == 1);
      early   = ($urandom_range(0, 7) == 0);
      run_len = cn ? $urandom_range(5, 80) : 2000;
      stop_at = early ? $urandom_range(0, 20) : -1;
      if (cn) stop_at = run_len;
      drive_start(fs, fe, st, dw, cn, tr);
      timed_out = 1'b1;
      for (int k = 0; k < 2000; k++) begin
        @(posedge clk); #1;
        start    = 1'b0;
        ld_ap    = ($urandom_range(0, 9) == 0);
        amp_in   = AW'($urandom);
        phase_in = PW'($urandom);
        f_start  = FW'($urandom);
        f_stop   = FW'($urandom);
        f_step   = FW'($urandom);
        dwell    = DW'($urandom_range(0, 5));
        cont     = $urandom_range(0, 1) == 1;
        tri_sel  = $urandom_range(0, 1) == 1;
        stop     = (k == stop_at);
        @(negedge clk);
        if (!busy && k > 0) begin
          timed_out = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
      stop  = 1'b0;
      ld_ap = 1'b0;
      if (timed_out) begin
        check("random_sweep_timeout", 1, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
      end
      $display("txn rnd%0d: %0d->%0d step=%0d dwell=%0d cont=%0b tri=%0b early_stop=%0b",
               t, fs, fe, st, dw, cn, tr, early);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
